// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a single combinational ALU.
// Takes one operation at a time, executes it for one cycle and returns the result.
module alu_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CTRL_W  = 5,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  // requester 0 (core datapath)
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [CTRL_W-1:0]  req0_ctrl,
  // requester 1 (auxiliary/debug engine)
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [CTRL_W-1:0]  req1_ctrl,
  // responses
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_result,
  output logic               rsp0_zero,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_result,
  output logic               rsp1_zero,
  // shared ALU
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [CTRL_W-1:0]  alu_ctrl,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 grant_id_q, grant_id_d;
  logic [DATA_W-1:0]    alu_a_q, alu_a_d;
  logic [DATA_W-1:0]    alu_b_q, alu_b_d;
  logic [SHAMT_W-1:0]   alu_shamt_q, alu_shamt_d;
  logic [CTRL_W-1:0]    alu_ctrl_q, alu_ctrl_d;
  logic                 rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0]    rsp0_result_q, rsp0_result_d;
  logic                 rsp0_zero_q, rsp0_zero_d;
  logic                 rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]    rsp1_result_q, rsp1_result_d;
  logic                 rsp1_zero_q, rsp1_zero_d;
  logic                 busy_q, busy_d;
  logic                 grant0_c, grant1_c;

  // Round-robin pick in IDLE: on a tie the port not granted last time wins.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        grant0_c = 1'b1;
      end else if (req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_shamt_d   = alu_shamt_q;
    alu_ctrl_d    = alu_ctrl_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant0_c) begin
          alu_a_d      = req0_a;
          alu_b_d      = req0_b;
          alu_shamt_d  = req0_shamt;
          alu_ctrl_d   = req0_ctrl;
          grant_id_d   = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_EXEC;
        end else if (grant1_c) begin
          alu_a_d      = req1_a;
          alu_b_d      = req1_b;
          alu_shamt_d  = req1_shamt;
          alu_ctrl_d   = req1_ctrl;
          grant_id_d   = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU output is captured untouched, zero flag sense included.
        if (grant_id_q) begin
          rsp1_valid_d  = 1'b1;
          rsp1_result_d = alu_result;
          rsp1_zero_d   = alu_zero;
        end else begin
          rsp0_valid_d  = 1'b1;
          rsp0_result_d = alu_result;
          rsp0_zero_d   = alu_zero;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (grant_id_q && rsp1_ready) begin
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else if (!grant_id_q && rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_shamt_q   <= '0;
      alu_ctrl_q    <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_shamt_q   <= alu_shamt_d;
      alu_ctrl_q    <= alu_ctrl_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
      busy_q        <= busy_d;
    end
  end

  assign req0_ready  = grant0_c;
  assign req1_ready  = grant1_c;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_shamt   = alu_shamt_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stub, directed scenarios and a randomized
// phase checked against an operation-level reference model.
module tb_alu_arbiter;

  localparam logic [4:0] OP_ADDU = 5'd1;
  localparam logic [4:0] OP_SUBU = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_BNE  = 5'd8;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req0_ctrl, req1_shamt, req1_ctrl;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt, alu_ctrl;
  logic        alu_zero, busy;

  int  n_pass = 0;
  int  n_total = 0;
  bit  last_model;
  logic [31:0] got_res;
  logic        got_zero;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_shamt(req0_shamt), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_shamt(req1_shamt), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: {zero, result}; BNE reports zero when operands differ.
  function automatic logic [32:0] alu_fn(input logic [4:0] c, input logic [31:0] a, b,
                                         input logic [4:0] s);
    logic [31:0] r;
    logic        z;
    case (c)
      OP_ADDU: r = a + b;
      OP_SUBU: r = a - b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = b << s;
      OP_SRL:  r = b >> s;
      OP_BNE:  r = a - b;
      default: r = a ^ ~b;
    endcase
    z = (r == 32'd0);
    if (c == OP_BNE) z = (a != b);
    return {z, r};
  endfunction

  always_comb {alu_zero, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b, alu_shamt);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offer one operation (entered at a falling edge, in IDLE), follow it to completion.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [4:0] s0, input logic [4:0] c0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic [4:0] s1, input logic [4:0] c1,
                        input int hold, output logic [31:0] res, output logic zf);
    bit          ok;
    bit          ep;
    logic [32:0] exp;
    logic [31:0] ea, eb;
    logic [4:0]  es, ec;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_shamt = s0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_shamt = s1; req1_ctrl = c1;
    ep = (v0 && v1) ? !last_model : v1;
    ok = 1'b0;
    res = '0;
    zf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ready_seen", 32'(ok), 32'd1);
    if (!ok) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    chk("grant0", 32'(req0_ready), 32'(!ep));
    chk("grant1", 32'(req1_ready), 32'(ep));
    last_model = ep;
    ea = ep ? a1 : a0; eb = ep ? b1 : b0; es = ep ? s1 : s0; ec = ep ? c1 : c0;
    exp = alu_fn(ec, ea, eb, es);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_sh", 32'(alu_shamt), 32'(es));
    chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(ec));
    chk("exec_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    @(negedge clk);
    chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}), ep ? 32'd2 : 32'd1);
    res = ep ? rsp1_result : rsp0_result;
    zf  = ep ? rsp1_zero : rsp0_zero;
    chk("rsp_result", res, exp[31:0]);
    chk("rsp_zero", 32'(zf), 32'(exp[32]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'({rsp1_valid, rsp0_valid}), ep ? 32'd2 : 32'd1);
      chk("hold_result", ep ? rsp1_result : rsp0_result, exp[31:0]);
    end
    if (ep) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk("rsp_cleared", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int grants;
    bit timed_out;
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_shamt = 0; req0_ctrl = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_shamt = 0; req1_ctrl = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    last_model = 1'b1;

    // Reset state, including ready suppression while rst is high
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_rsp", 32'({rsp1_valid, rsp0_valid, rsp1_zero, rsp0_zero}), 32'd0);
    chk("rst_rsp_res", rsp0_result | rsp1_result, 32'd0);
    req0_valid = 1'b0;

    // Tie and alternation from reset: expect grants 0,1,0,1
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1; req0_a = 32'd7;    req0_b = 32'd7;    req0_ctrl = OP_SUBU;
    req1_valid = 1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_ctrl = OP_OR;
    rsp0_ready = 1; rsp1_ready = 1;
    grants = 0;
    for (int cyc = 0; cyc < 24 && grants < 4; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("tie_order", 32'(req1_ready), 32'(grants % 2));
        grants++;
      end
      if (rsp0_valid) begin
        chk("tie_res0", rsp0_result, 32'd0);
        chk("tie_zero0", 32'(rsp0_zero), 32'd1);
      end
      if (rsp1_valid) begin
        chk("tie_res1", rsp1_result, 32'hFF);
        chk("tie_zero1", 32'(rsp1_zero), 32'd0);
      end
      @(negedge clk);
    end
    chk("tie_grants", 32'(grants), 32'd4);
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 10 && (busy || rsp0_valid || rsp1_valid); i++) begin
      if (rsp1_valid) chk("tie_res1_last", rsp1_result, 32'hFF);
      @(negedge clk);
    end
    chk("tie_drained", 32'(busy), 32'd0);
    rsp0_ready = 0; rsp1_ready = 0;
    last_model = 1'b1;

    // Single ADDU on port 0
    run_op(1, 0, 32'd5, 32'd3, 5'd0, OP_ADDU, 32'd0, 32'd0, 5'd0, 5'd0, 0, got_res, got_zero);
    chk("addu_res", got_res, 32'h8);
    chk("addu_zero", 32'(got_zero), 32'd0);

    // Back-pressure on port 1 while port 0 waits
    req1_valid = 1; req1_a = 32'd0; req1_b = 32'h1; req1_shamt = 5'd4; req1_ctrl = OP_SLL;
    #1;
    chk("bp_ready1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_shamt = 5'd0; req0_ctrl = OP_ADDU;
    #1;
    chk("bp_exec_ready0", 32'(req0_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid1", 32'(rsp1_valid), 32'd1);
      chk("bp_res1", rsp1_result, 32'h10);
      chk("bp_ready0", 32'(req0_ready), 32'd0);
      @(negedge clk);
    end
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;
    #1;
    chk("bp_taken", 32'(rsp1_valid), 32'd0);
    chk("bp_accept0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    chk("bp_res0", rsp0_result, 32'd2);
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    chk("bp_done", 32'({busy, rsp0_valid}), 32'd0);
    last_model = 1'b0;

    // BNE flag passes through with its inverted sense
    run_op(1, 0, 32'd1, 32'd2, 5'd0, OP_BNE, 32'd0, 32'd0, 5'd0, 5'd0, 1, got_res, got_zero);
    chk("bne_res", got_res, 32'hFFFF_FFFF);
    chk("bne_zero", 32'(got_zero), 32'd1);

    // Idle stability
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_alu_a", alu_a, 32'd1);
      chk("idle_alu_b", alu_b, 32'd2);
      chk("idle_alu_ctrl", 32'(alu_ctrl), 32'(OP_BNE));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'({req1_ready, req0_ready}), 32'd0);
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      run_op(pat[0], pat[1], $urandom, $urandom, 5'($urandom), 5'($urandom_range(0, 12)),
             $urandom, $urandom, 5'($urandom), 5'($urandom_range(0, 12)),
             int'($urandom_range(0, 3)), got_res, got_zero);
    end

    // Reset while in RESP discards the response
    req0_valid = 1; req0_a = 32'd9; req0_b = 32'd4; req0_shamt = 0; req0_ctrl = OP_SUBU;
    #1;
    chk("rr_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    chk("rr_valid", 32'(rsp0_valid), 32'd1);
    chk("rr_res", rsp0_result, 32'd5);
    #2 rst = 1;
    #1;
    chk("rr_async_valid", 32'(rsp0_valid), 32'd0);
    chk("rr_async_busy", 32'(busy), 32'd0);
    chk("rr_async_res", rsp0_result, 32'd0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rr_ready_in_rst", 32'({req1_ready, req0_ready}), 32'd0);
    @(negedge clk);
    rst = 0;
    last_model = 1'b1;
    #1;
    chk("rr_first0", 32'(req0_ready), 32'd1);
    chk("rr_first1", 32'(req1_ready), 32'd0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    run_op(1, 1, 32'd3, 32'd3, 5'd0, OP_XOR, 32'd8, 32'd1, 5'd0, OP_AND, 0, got_res, got_zero);
    chk("rr_after_zero", 32'(got_zero), 32'd1);

    timed_out = (n_total == 0);
    if (timed_out) $error("FAIL no_checks: observed 0 expected >0");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the core datapath and port 1 is the auxiliary/debug engine.
- Each requester hands over an operation (operands, shift amount, ALU control code) with a valid/ready handshake.
- The arbiter grants one operation at a time, round-robin, and registers the operands onto the ALU inputs for one execute cycle.
- It captures the ALU result and zero flag, then returns them on the granted requester's response channel, held until accepted.

Parameters:
- DATA_W, 32, operand/result width.
- CTRL_W, 5, ALU control code width; codes are the ALUOp_* values from ctrl_encode_def.v.
- SHAMT_W, 5, shift-amount width.

Ports:
- clk in 1: single clock, rising edge.
- rst in 1: asynchronous reset, active-high.
- req0_valid / req1_valid in 1: requester n offers an operation.
- req0_ready / req1_ready out 1: arbiter accepts requester n this cycle.
- req0_a / req1_a in DATA_W: operand 1.
- req0_b / req1_b in DATA_W: operand 2.
- req0_shamt / req1_shamt in SHAMT_W: shift amount.
- req0_ctrl / req1_ctrl in CTRL_W: ALU operation code.
- rsp0_valid / rsp1_valid out 1: result for requester n is available.
- rsp0_ready / rsp1_ready in 1: requester n takes its result.
- rsp0_result / rsp1_result out DATA_W: captured ALU result.
- rsp0_zero / rsp1_zero out 1: captured ALU zero flag.
- alu_a out DATA_W, alu_b out DATA_W, alu_shamt out SHAMT_W, alu_ctrl out CTRL_W: registered ALU inputs.
- alu_result in DATA_W, alu_zero in 1: ALU outputs (combinational).
- busy out 1: high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=1 (port 0 wins the first tie), grant_id=0.
  - alu_a/alu_b/alu_shamt/alu_ctrl=0.
  - All rsp*_valid=0, rsp*_result=0, rsp*_zero=0.
  - req*_ready=0 while rst is high, busy=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational and only ever asserted in IDLE, for at most one port.
  - Only req0_valid: req0_ready=1. Only req1_valid: req1_ready=1.
  - Both valid: grant the port != last_grant.
  - On a handshake (valid&&ready at edge): load the alu_* registers from that port, set grant_id and last_grant to that port, and go to EXEC.
  - No valid: stay in IDLE; the alu_* registers hold their last values.
- EXEC (exactly 1 cycle):
  - The ALU sees stable registered inputs.
  - At the closing edge, capture alu_result/alu_zero into rsp{grant_id}_result/_zero, set rsp{grant_id}_valid=1, and go to RESP.
- RESP:
  - rsp{grant_id}_valid stays high and result/zero stay stable until rsp{grant_id}_ready=1 at an edge.
  - At that edge: clear valid and go to IDLE.
  - The other port's rsp_valid stays 0 throughout.
- Latency and throughput:
  - Handshake at edge T → rsp_valid visible in cycle T+2.
  - Zero back-pressure gives 3 cycles per operation.
  - A new request is not accepted before IDLE.
- rsp_result/rsp_zero keep their last captured value after valid drops; they are meaningful only while valid.
- The zero flag is passed through exactly as the ALU produces it, including the inverted sense for ALUOp_BNE. No re-derivation.
- The arbiter never inspects ctrl. Unknown codes pass to the ALU unchanged.
- Requester rules:
  - A requester holding valid may change operands only after its ready handshake.
  - A requester that drops valid before being granted is simply not served; no state change.
- Fairness: with both ports valid continuously, grants alternate 0,1,0,1,…
- rst mid-operation (EXEC or RESP): the operation is discarded with no response. All state returns to reset values immediately; the first grant after reset goes to port 0.
- busy = (state != IDLE).

Test Plan:
- Single ADDU request:
  - Stimulus: req0 only, a=0x0000_0005, b=0x0000_0003, ctrl=ALUOp_ADDU, rsp0_ready=1.
  - Response: req0_ready high in cycle 0; rsp0_valid in cycle 2 with result=0x8, zero=0; rsp1_valid stays 0.
- Tie and alternation:
  - Stimulus: both ports valid continuously from reset, port 0 SUBU 7-7 and port 1 OR 0xF0|0x0F, rsp*_ready=1.
  - Response: grant order 0,1,0,1; port 0 gets result=0, zero=1; port 1 gets result=0xFF.
- Back-pressure:
  - Stimulus: req1 SLL with b=0x1, shamt=4; rsp1_ready held 0 for 5 cycles.
  - Response: rsp1_valid=1 with result=0x10 held stable all 5 cycles; req0_ready stays 0 while req0 is valid; port 0 is accepted in the first IDLE cycle after rsp1 is taken.
- BNE flag:
  - Stimulus: req0 ALUOp_BNE, a=1, b=2.
  - Response: rsp0_zero=1, rsp0_result=0xFFFF_FFFF.
- Reset in RESP:
  - Stimulus: assert rst while rsp0_valid=1, then release rst with both ports valid.
  - Response: rsp0_valid drops to 0 asynchronously, busy=0, and the first grant after release is port 0.
- Idle stability:
  - Stimulus: no requests for 10 cycles after one completed operation.
  - Response: the alu_* outputs hold that operation's operands, busy=0, and both req*_ready stay 0.
